// File: rtl/fec_decode_arbiter.sv
// ============================================================================
// Module  : fec_decode_arbiter
// Desc    : Round-robin sharing of one SECDED decoder between N_REQ lanes.
//           Optional WAIT abort on silent decoder: define FEC_ARB_TIMEOUT_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module fec_decode_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [N_REQ-1:0]     req,
    input  logic [16*N_REQ-1:0]  data_in,
    output logic [N_REQ-1:0]     ack,
    output logic [7:0]           data_out,
    output logic                 rsp_timeout,
    output logic                 busy,
    output logic                 dec_en,
    output logic                 dec_req,
    output logic [15:0]          dec_data,
    input  logic                 dec_ack,
    input  logic [7:0]           dec_data_out
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    generate
        if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 1) begin : g_bad_params
            $error("fec_decode_arbiter: N_REQ must be 2..8 and TIMEOUT >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t             r_state, w_state_nx;
    logic [IDX_W-1:0]   r_ptr, w_ptr_nx;
    logic [IDX_W-1:0]   r_grant, w_grant_nx;
    logic [15:0]        r_dec_data, w_dec_data_nx;
    logic               r_dec_en, w_dec_en_nx;
    logic               r_dec_req, w_dec_req_nx;
    logic [N_REQ-1:0]   r_ack, w_ack_nx;
    logic [7:0]         r_data_out, w_data_out_nx;
    logic               r_busy;
    logic               w_timeout_nx;
    logic               w_abort;

    // Round-robin pick: first request above the pointer, else lowest overall.
    logic               w_hi_found, w_lo_found;
    logic [IDX_W-1:0]   w_hi, w_lo, w_sel;
    logic [15:0]        w_sel_word;

    always_comb begin
        w_hi_found = 1'b0;
        w_lo_found = 1'b0;
        w_hi       = '0;
        w_lo       = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                w_lo_found = 1'b1;
                w_lo       = IDX_W'(i);
                if (IDX_W'(i) > r_ptr) begin
                    w_hi_found = 1'b1;
                    w_hi       = IDX_W'(i);
                end
            end
        end
        w_sel      = w_hi_found ? w_hi : w_lo;
        w_sel_word = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_sel == IDX_W'(i)) begin
                w_sel_word = data_in[16*i +: 16];
            end
        end
    end

`ifdef FEC_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_rsp_timeout;

    assign w_abort = (r_wait_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt    <= '0;
            r_rsp_timeout <= 1'b0;
        end else begin
            if (r_state == S_ISSUE) begin
                r_wait_cnt <= '0;
            end else if (r_state == S_WAIT) begin
                r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            end
            r_rsp_timeout <= w_timeout_nx;
        end
    end

    assign rsp_timeout = r_rsp_timeout;
`else
    assign w_abort     = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    always_comb begin
        w_state_nx    = r_state;
        w_ptr_nx      = r_ptr;
        w_grant_nx    = r_grant;
        w_dec_data_nx = r_dec_data;
        w_dec_en_nx   = 1'b0;
        w_dec_req_nx  = 1'b0;
        w_ack_nx      = '0;
        w_data_out_nx = '0;
        w_timeout_nx  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (en && w_lo_found) begin
                    w_state_nx    = S_ISSUE;
                    w_grant_nx    = w_sel;
                    w_dec_data_nx = w_sel_word;
                    w_dec_en_nx   = 1'b1;
                    w_dec_req_nx  = 1'b1;
                end
            end
            S_ISSUE: begin
                w_state_nx   = S_WAIT;
                w_dec_en_nx  = 1'b1;
                w_dec_req_nx = 1'b1;
            end
            S_WAIT: begin
                w_dec_en_nx  = 1'b1;
                w_dec_req_nx = 1'b1;
                if (dec_ack || w_abort) begin
                    w_state_nx    = S_RESP;
                    w_ptr_nx      = r_grant;
                    w_dec_en_nx   = 1'b0;
                    w_dec_req_nx  = 1'b0;
                    w_data_out_nx = dec_ack ? dec_data_out : 8'h00;
                    w_timeout_nx  = ~dec_ack;
                    for (int i = 0; i < N_REQ; i++) begin
                        w_ack_nx[i] = (r_grant == IDX_W'(i));
                    end
                end
            end
            S_RESP: begin
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_ptr      <= IDX_W'(N_REQ - 1);
            r_grant    <= '0;
            r_dec_data <= '0;
            r_dec_en   <= 1'b0;
            r_dec_req  <= 1'b0;
            r_ack      <= '0;
            r_data_out <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_ptr      <= w_ptr_nx;
            r_grant    <= w_grant_nx;
            r_dec_data <= w_dec_data_nx;
            r_dec_en   <= w_dec_en_nx;
            r_dec_req  <= w_dec_req_nx;
            r_ack      <= w_ack_nx;
            r_data_out <= w_data_out_nx;
            r_busy     <= (w_state_nx != S_IDLE);
        end
    end

    assign ack      = r_ack;
    assign data_out = r_data_out;
    assign busy     = r_busy;
    assign dec_en   = r_dec_en;
    assign dec_req  = r_dec_req;
    assign dec_data = r_dec_data;

endmodule

`default_nettype wire
